// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: Wishbone controller that drains the UART on each RX interrupt
// into a 16-entry byte FIFO, plus a Wishbone peripheral port for the CPU to
// pop bytes (DATA) and inspect/clear flags (STATUS).
module uart_rx_fifo #(
  parameter logic [31:0] ADR_DATA   = 32'h0000_0100,
  parameter logic [31:0] ADR_STAT   = 32'h0000_0101,
  parameter logic [31:0] UART_ADR   = 32'h0000_00FF,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [3:0]  TIMEOUT    = 4'd15
) (
  input  logic        clk_48_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [31:0] m_adr_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        uart_irq_i,
  output logic        irq_o
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ZERO_CNT = {(DEPTH_LOG2+1){1'b0}};

  typedef enum logic [2:0] {
    M_IDLE = 3'b001,
    M_READ = 3'b010,
    M_COOL = 3'b100
  } m_state_t;

  m_state_t                state_r;
  logic [3:0]              tmo_r;
  logic                    m_cyc_r;
  logic                    m_stb_r;
  logic [7:0]              mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [DEPTH_LOG2:0]     count_r;
  logic [DEPTH_LOG2:0]     count_next_s;
  logic                    ovf_r;
  logic                    err_r;
  logic                    irq_r;
  logic                    ack_r;
  logic [31:0]             dat_r;

  logic hit_data_s;
  logic hit_stat_s;
  logic acc_s;
  logic stat_wr_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic ack_in_s;
  logic push_s;
  logic push_ok_s;
  logic ovf_set_s;
  logic tmo_s;
  logic unused_s;

  // A floating or unknown UART ack must never count as an acknowledge.
  assign ack_in_s   = (m_ack_i === 1'b1);

  assign hit_data_s = (adr_i == ADR_DATA);
  assign hit_stat_s = (adr_i == ADR_STAT);
  // ack_r blocks the cycle right after an ack, so a held strobe is one access.
  assign acc_s      = cyc_i & stb_i & ~ack_r & (hit_data_s | hit_stat_s);
  assign stat_wr_s  = acc_s & hit_stat_s & we_i;

  assign empty_s    = (count_r == ZERO_CNT);
  assign full_s     = (count_r == FULL_CNT);
  assign pop_s      = acc_s & hit_data_s & ~we_i & ~empty_s;

  assign push_s     = (state_r == M_READ) & ack_in_s;
  // A same-edge pop frees a slot, so a push into a full FIFO is still taken.
  assign push_ok_s  = push_s & (~full_s | pop_s);
  assign ovf_set_s  = push_s & full_s & ~pop_s;
  // The last wait cycle is the one where the counter would decrement to 0.
  assign tmo_s      = (state_r == M_READ) & ~ack_in_s & (tmo_r <= 4'd1);

  assign unused_s   = ^{dat_i[31:12], dat_i[10:9], dat_i[7:0], m_dat_i[31:8]};

  assign m_adr_o    = UART_ADR;
  assign m_we_o     = 1'b0;
  assign m_cyc_o    = m_cyc_r;
  assign m_stb_o    = m_stb_r;
  assign ack_o      = ack_r;
  assign dat_o      = dat_r;
  assign irq_o      = irq_r;

  // Next FIFO occupancy from the push/pop pair of this cycle.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Controller FSM: one UART read per interrupt, with ack timeout and cool-down.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= M_IDLE;
      tmo_r   <= 4'd0;
      m_cyc_r <= 1'b0;
      m_stb_r <= 1'b0;
    end else begin
      case (state_r)
        M_IDLE: begin
          if (uart_irq_i) begin
            state_r <= M_READ;
            tmo_r   <= TIMEOUT;
            m_cyc_r <= 1'b1;
            m_stb_r <= 1'b1;
          end
        end
        M_READ: begin
          if (ack_in_s || tmo_s) begin
            state_r <= M_COOL;
            m_cyc_r <= 1'b0;
            m_stb_r <= 1'b0;
          end else begin
            tmo_r   <= tmo_r - 4'd1;
          end
        end
        M_COOL: begin
          state_r <= M_IDLE;
        end
        default: begin
          state_r <= M_IDLE;
          m_cyc_r <= 1'b0;
          m_stb_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents are meaningless after reset since pointers clear.
  always_ff @(posedge clk_48_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= m_dat_i[7:0];
    end
  end

  // FIFO pointers, occupancy and the registered not-empty interrupt.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= ZERO_CNT;
      irq_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r <= count_next_s;
      irq_r   <= (count_next_s != ZERO_CNT);
    end
  end

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (stat_wr_s && dat_i[8]) begin
        ovf_r <= 1'b0;
      end
      if (tmo_s) begin
        err_r <= 1'b1;
      end else if (stat_wr_s && dat_i[11]) begin
        err_r <= 1'b0;
      end
    end
  end

  // CPU port: single-cycle registered ack and read data.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= acc_s;
      if (acc_s) begin
        if (we_i) begin
          dat_r <= 32'h0000_0000;
        end else if (hit_data_s) begin
          dat_r <= pop_s ? {23'h000000, 1'b1, mem_r[rd_ptr_r]} : 32'h0000_0000;
        end else begin
          dat_r <= {20'h00000, err_r, empty_s, full_s, ovf_r, 3'b000, 5'(count_r)};
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a UART responder model feeds a byte
// scoreboard, CPU DATA reads pop and compare against it, and STATUS reads are
// compared against flags tracked by the bench.
module tb_uart_rx_fifo;

  localparam logic [31:0] ADR_DATA = 32'h0000_0100;
  localparam logic [31:0] ADR_STAT = 32'h0000_0101;

  logic        clk_48_i = 1'b0;
  logic        rst_i    = 1'b1;
  logic [31:0] adr_i    = 32'h0;
  logic [31:0] dat_i    = 32'h0;
  logic        we_i     = 1'b0;
  logic        stb_i    = 1'b0;
  logic        cyc_i    = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [31:0] m_adr_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_dat_i    = 32'h0;
  logic        m_ack_i    = 1'b0;
  logic        uart_irq_i = 1'b0;
  logic        irq_o;

  uart_rx_fifo dut (
    .clk_48_i   (clk_48_i),
    .rst_i      (rst_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .we_i       (we_i),
    .stb_i      (stb_i),
    .cyc_i      (cyc_i),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .m_adr_o    (m_adr_o),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack_i),
    .uart_irq_i (uart_irq_i),
    .irq_o      (irq_o)
  );

  always #10 clk_48_i = ~clk_48_i;

  logic [7:0] sb_q [$];
  bit         ovf_exp = 1'b0;
  bit         err_exp = 1'b0;
  int         n_chk   = 0;
  int         n_pass  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] exp_stat();
    logic [4:0] c;
    logic       e;
    logic       f;
    c = 5'(sb_q.size());
    e = (sb_q.size() == 0);
    f = (sb_q.size() == 16);
    exp_stat = {20'h00000, err_exp, e, f, ovf_exp, 3'b000, c};
  endfunction

  task automatic sb_push(input logic [7:0] b);
    if (sb_q.size() < 16) sb_q.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  // Start at a negedge; returns at the negedge where ack_o is seen.
  task automatic cpu_acc(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    bit got;
    got   = 1'b0;
    adr_i = adr; we_i = we; dat_i = wdat; cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_48_i);
      if (ack_o) begin
        got = 1'b1;
        break;
      end
    end
    rdat  = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = 32'h0;
    if (!got) check_val("cpu_ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] r;
    logic [31:0] e;
    if (sb_q.size() != 0) e = {23'h000000, 1'b1, sb_q.pop_front()};
    else e = 32'h0;
    cpu_acc(ADR_DATA, 1'b0, 32'h0, r);
    check_val(tag, r, e);
  endtask

  task automatic read_stat(input string tag);
    logic [31:0] r;
    logic [31:0] e;
    e = exp_stat();
    cpu_acc(ADR_STAT, 1'b0, 32'h0, r);
    check_val(tag, r, e);
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_48_i);
      if (m_stb_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("stb_timeout", 32'(ok), 32'd1);
  endtask

  // UART responder: raise irq, ack one cycle after strobe, drop irq when read.
  task automatic uart_send(input logic [7:0] b);
    bit ok;
    m_dat_i    = {24'hABCDEF, b};
    uart_irq_i = 1'b1;
    wait_stb(ok);
    uart_irq_i = 1'b0;
    if (ok) begin
      m_ack_i = 1'b1;
      sb_push(b);
      @(negedge clk_48_i);
      m_ack_i = 1'b0;
    end
    @(negedge clk_48_i);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [31:0] e;
    bit          ok;
    int          n;

    repeat (3) @(negedge clk_48_i);
    rst_i = 1'b0;
    @(negedge clk_48_i);

    // Reset state
    check_val("rst_dat_o", dat_o, 32'h0);
    check_val("rst_ack_o", 32'(ack_o), 32'h0);
    check_val("rst_m_cyc", 32'(m_cyc_o), 32'h0);
    check_val("rst_m_stb", 32'(m_stb_o), 32'h0);
    check_val("rst_m_we", 32'(m_we_o), 32'h0);
    check_val("rst_m_adr", m_adr_o, 32'h0000_00FF);
    check_val("rst_irq_o", 32'(irq_o), 32'h0);
    cpu_acc(ADR_STAT, 1'b0, 32'h0, r);
    check_val("rst_status", r, 32'h0000_0400);

    // Single byte
    uart_send(8'h41);
    check_val("one_irq_o", 32'(irq_o), 32'h1);
    read_stat("one_status");
    cpu_acc(ADR_DATA, 1'b1, 32'h0000_00EE, r);
    read_stat("data_write_noeffect");
    cpu_acc(ADR_DATA, 1'b0, 32'h0, r);
    check_val("one_data", r, 32'h0000_0141);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk_48_i);
    check_val("one_irq_clear", 32'(irq_o), 32'h0);
    read_data("empty_read");

    // Overflow: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) uart_send(8'(i));
    read_stat("full_status");
    check_val("full_status_const", exp_stat(), 32'h0000_0310);
    for (int i = 0; i < 16; i++) read_data($sformatf("drain_%0d", i));
    read_data("drain_empty");
    cpu_acc(ADR_STAT, 1'b1, 32'h0000_0100, r);
    ovf_exp = 1'b0;
    read_stat("ovf_cleared");

    // Simultaneous pop and push at full
    for (int i = 0; i < 16; i++) uart_send(8'(8'h20 + i));
    m_dat_i    = {24'h123456, 8'h55};
    uart_irq_i = 1'b1;
    wait_stb(ok);
    uart_irq_i = 1'b0;
    e = {23'h000000, 1'b1, sb_q.pop_front()};
    sb_push(8'h55);
    m_ack_i = 1'b1;
    adr_i = ADR_DATA; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(negedge clk_48_i);
    m_ack_i = 1'b0;
    check_val("sim_ack", 32'(ack_o), 32'h1);
    r = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0;
    check_val("sim_pop", r, e);
    @(negedge clk_48_i);
    read_stat("sim_status");
    check_val("sim_status_const", exp_stat(), 32'h0000_0210);
    for (int i = 0; i < 16; i++) read_data($sformatf("sim_drain_%0d", i));

    // UART never acks
    uart_irq_i = 1'b1;
    wait_stb(ok);
    uart_irq_i = 1'b0;
    n = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_48_i);
      if (!m_cyc_o) break;
      n++;
    end
    check_val("tmo_cycles", 32'(n), 32'd15);
    check_val("tmo_stb_drop", 32'(m_stb_o), 32'h0);
    err_exp = 1'b1;
    @(negedge clk_48_i);
    read_stat("tmo_err");
    cpu_acc(ADR_STAT, 1'b1, 32'h0000_0800, r);
    err_exp = 1'b0;
    read_stat("err_cleared");

    // Reset during a UART read
    for (int i = 0; i < 3; i++) uart_send(8'(8'h70 + i));
    read_stat("pre_rst_status");
    uart_irq_i = 1'b1;
    wait_stb(ok);
    rst_i = 1'b1;
    #1;
    check_val("rst_mid_cyc", 32'(m_cyc_o), 32'h0);
    check_val("rst_mid_stb", 32'(m_stb_o), 32'h0);
    check_val("rst_mid_irq", 32'(irq_o), 32'h0);
    uart_irq_i = 1'b0;
    sb_q.delete();
    ovf_exp = 1'b0;
    err_exp = 1'b0;
    repeat (2) @(negedge clk_48_i);
    rst_i = 1'b0;
    @(negedge clk_48_i);
    read_stat("post_rst_status");
    read_data("post_rst_empty");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
